// File: rtl/vga_frame_reader_if.sv
// Bundles the memory read port, bank request and DAC-side pixel/sync signals of the VGA scan stage.
// The master modport is the scan stage; the slave modport is the memory/DAC side.
interface vga_frame_reader_if;
   logic        bank_sel;
   logic [15:0] mem_data;
   logic [14:0] mem_addr;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        o_hs;
   logic        o_vs;
   logic        o_sync;
   logic        o_blank;
   logic        frame_start;

   modport master (
      input  bank_sel,
      input  mem_data,
      output mem_addr,
      output r,
      output g,
      output b,
      output o_hs,
      output o_vs,
      output o_sync,
      output o_blank,
      output frame_start
   );

   modport slave (
      output bank_sel,
      output mem_data,
      input  mem_addr,
      input  r,
      input  g,
      input  b,
      input  o_hs,
      input  o_vs,
      input  o_sync,
      input  o_blank,
      input  frame_start
   );
endinterface

// File: rtl/vga_frame_reader.sv
// VGA scan stage: 640x480 timing, multiplier-free address walk of a scaled image window and
// a grey-level pixel output pipeline aligned with the registered memory read.
module vga_frame_reader #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned IMG_W    = 100,
   parameter int unsigned IMG_H    = 100,
   parameter int unsigned SCALE    = 4,
   parameter int unsigned X0       = 120,
   parameter int unsigned Y0       = 40,
   parameter logic [7:0]  BORDER   = 8'h00
) (
   input logic                 o_clk,
   input logic                 rst,
   vga_frame_reader_if.master  vga_io
);

   localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW     = $clog2(HTotal);
   localparam int unsigned VW     = $clog2(VTotal);
   localparam int unsigned CW     = $clog2(IMG_W + 1);
   localparam int unsigned SW     = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int unsigned XEnd   = X0 + IMG_W * SCALE;
   localparam int unsigned YEnd   = Y0 + IMG_H * SCALE;

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [CW-1:0] col_q, col_d, col_e;
   logic [SW-1:0] sx_q, sx_d, sx_e;
   logic [SW-1:0] sy_q, sy_d, sy_e;
   logic [13:0]   row_q, row_d, row_e;
   logic [14:0]   addr_q, addr_d;
   logic          bank_q, bank_e;

   logic vis0, win0, hs0_n, vs0_n, line_start, fs0;
   logic vis1_q, win1_q, hs1_q, vs1_q;
   logic [7:0] pix_q, pix_d;
   logic blank_q, hs_q, vs_q;

   // Raw stage-0 decode of the counters
   always_comb begin
      line_start = (h_q == '0);
      fs0        = line_start && (v_q == '0);
      vis0       = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
      hs0_n      = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs0_n      = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
      win0       = (h_q >= HW'(X0)) && (h_q < HW'(XEnd)) &&
                   (v_q >= VW'(Y0)) && (v_q < VW'(YEnd));
   end

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == HW'(HTotal - 1)) begin
         h_d = '0;
         v_d = (v_q == VW'(VTotal - 1)) ? '0 : v_q + 1'b1;
      end
   end

   // Line/frame clears are folded in combinationally so a window touching the screen origin
   // still starts from a clean column, row and bank.
   always_comb begin
      col_e  = line_start ? '0 : col_q;
      sx_e   = line_start ? '0 : sx_q;
      row_e  = fs0 ? '0 : row_q;
      sy_e   = fs0 ? '0 : sy_q;
      bank_e = fs0 ? vga_io.bank_sel : bank_q;

      col_d  = col_e;
      sx_d   = sx_e;
      row_d  = row_e;
      sy_d   = sy_e;
      addr_d = addr_q;

      if (win0) begin
         addr_d = {bank_e, row_e + 14'(col_e)};
         if (sx_e == SW'(SCALE - 1)) begin
            sx_d  = '0;
            col_d = col_e + 1'b1;
         end else begin
            sx_d  = sx_e + 1'b1;
         end
         if (h_q == HW'(XEnd - 1)) begin
            if (sy_e == SW'(SCALE - 1)) begin
               sy_d  = '0;
               row_d = row_e + 14'(IMG_W);
            end else begin
               sy_d  = sy_e + 1'b1;
            end
         end
      end
   end

   always_comb begin
      if (!vis1_q) begin
         pix_d = 8'h00;
      end else if (win1_q) begin
         pix_d = vga_io.mem_data[7:0];
      end else begin
         pix_d = BORDER;
      end
   end

   always_ff @(posedge o_clk) begin
      if (rst) begin
         h_q     <= '0;
         v_q     <= '0;
         col_q   <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         bank_q  <= 1'b0;
         vis1_q  <= 1'b0;
         win1_q  <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         pix_q   <= 8'h00;
         blank_q <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         col_q   <= col_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         if (fs0) begin
            bank_q <= vga_io.bank_sel;
         end
         vis1_q  <= vis0;
         win1_q  <= win0;
         hs1_q   <= hs0_n;
         vs1_q   <= vs0_n;
         pix_q   <= pix_d;
         blank_q <= vis1_q;
         hs_q    <= hs1_q;
         vs_q    <= vs1_q;
      end
   end

   // Upper half of the memory word carries no pixel information
   logic unused_mem_hi;
   assign unused_mem_hi = ^vga_io.mem_data[15:8];

   assign vga_io.mem_addr    = addr_q;
   assign vga_io.r           = pix_q;
   assign vga_io.g           = pix_q;
   assign vga_io.b           = pix_q;
   assign vga_io.o_blank     = blank_q;
   assign vga_io.o_hs        = hs_q;
   assign vga_io.o_vs        = vs_q;
   assign vga_io.o_sync      = 1'b0;
   assign vga_io.frame_start = fs0 && !rst;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced screen geometry: a screen-coordinate model
// predicts every cycle's pins and a separate monitor compares them as they appear.
module tb_vga_frame_reader;

   localparam int unsigned HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int unsigned VA = 48, VF = 2, VS = 2, VB = 3;
   localparam int unsigned IW = 10, IH = 8, SC = 4, XO = 12, YO = 6;
   localparam logic [7:0]  BRD = 8'h5A;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned FRAME = HT * VT;

   typedef struct {
      int          due;
      logic [31:0] val;
   } exp_t;

   logic o_clk = 1'b0;
   logic rst = 1'b1;
   logic bank_sel = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t fs_q[$];
   exp_t addr_q[$];
   exp_t pix_q[$];

   vga_frame_reader_if vga_io ();

   assign vga_io.bank_sel = bank_sel;
   // Memory returns its own address so the pixel value identifies the word that was read
   assign vga_io.mem_data = {1'b0, vga_io.mem_addr};

   vga_frame_reader #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .IMG_W    (IW), .IMG_H (IH), .SCALE (SC), .X0 (XO), .Y0 (YO),
      .BORDER   (BRD)
   ) dut (
      .o_clk  (o_clk),
      .rst    (rst),
      .vga_io (vga_io)
   );

   always #5 o_clk = ~o_clk;
   always @(posedge o_clk) cyc <= cyc + 1;

   function automatic exp_t mk(int d, logic [31:0] v);
      exp_t e;
      e.due = d;
      e.val = v;
      return e;
   endfunction

   function automatic logic [31:0] pack_pix(logic [7:0] p, logic blank, logic hs, logic vs,
                                            logic sync);
      return {4'h0, p, p, p, blank, hs, vs, sync};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
      end
   endtask

   // Reference model: screen position, window geometry and frame bank from the screen rules
   initial begin
      int          x, y, off;
      logic        bank, vis, hs, vs, win, fs;
      logic [14:0] a;
      logic [7:0]  p;
      x = 0; y = 0; bank = 1'b0; a = '0;
      forever begin
         @(negedge o_clk);
         if (rst) begin
            x = 0; y = 0; bank = 1'b0; a = '0;
            while (addr_q.size() > 0 && addr_q[addr_q.size()-1].due > cyc) void'(addr_q.pop_back());
            while (pix_q.size() > 0 && pix_q[pix_q.size()-1].due > cyc) void'(pix_q.pop_back());
            fs_q.push_back(mk(cyc, 32'd0));
            addr_q.push_back(mk(cyc + 1, 32'd0));
            pix_q.push_back(mk(cyc + 1, pack_pix(8'h00, 1'b0, 1'b1, 1'b1, 1'b0)));
            pix_q.push_back(mk(cyc + 2, pack_pix(8'h00, 1'b0, 1'b1, 1'b1, 1'b0)));
         end else begin
            vis = (x < HA) && (y < VA);
            hs  = !((x >= HA + HF) && (x < HA + HF + HS));
            vs  = !((y >= VA + VF) && (y < VA + VF + VS));
            win = (x >= XO) && (x < XO + IW * SC) && (y >= YO) && (y < YO + IH * SC);
            fs  = (x == 0) && (y == 0);
            if (fs) bank = bank_sel;
            if (win) begin
               off = ((y - YO) / SC) * IW + (x - XO) / SC;
               a = {bank, 14'(off)};
            end
            p = !vis ? 8'h00 : (win ? a[7:0] : BRD);
            fs_q.push_back(mk(cyc, 32'(fs)));
            addr_q.push_back(mk(cyc + 1, 32'(a)));
            pix_q.push_back(mk(cyc + 2, pack_pix(p, vis, hs, vs, 1'b0)));
            x++;
            if (x == HT) begin
               x = 0;
               y++;
               if (y == VT) y = 0;
            end
         end
      end
   end

   // Monitor: compares whatever the DUT presents against the entries due this cycle
   initial begin
      exp_t e;
      int   last_fs;
      bit   fs_valid;
      fs_valid = 1'b0;
      last_fs = 0;
      forever begin
         @(negedge o_clk);
         #1;
         while (fs_q.size() > 0 && fs_q[0].due <= cyc) begin
            e = fs_q.pop_front();
            check("frame_start", 32'(vga_io.frame_start), e.val);
         end
         while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            e = addr_q.pop_front();
            check("mem_addr", 32'(vga_io.mem_addr), e.val);
         end
         while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            e = pix_q.pop_front();
            check("pixel_rgb_blank_hs_vs_sync",
                  {4'h0, vga_io.r, vga_io.g, vga_io.b, vga_io.o_blank, vga_io.o_hs, vga_io.o_vs,
                   vga_io.o_sync}, e.val);
         end
         if (rst) begin
            fs_valid = 1'b0;
         end else if (vga_io.frame_start === 1'b1) begin
            if (fs_valid) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs  = cyc;
            fs_valid = 1'b1;
         end
      end
   end

   task automatic run(int n, int toggle_permille);
      repeat (n) begin
         @(posedge o_clk);
         #2;
         if ($urandom_range(0, 999) < toggle_permille) bank_sel = ~bank_sel;
      end
   endtask

   initial begin
      rst = 1'b1;
      bank_sel = 1'b0;
      run(3, 0);
      rst = 1'b0;
      // Bank request changes mid-frame; takes effect only from the next frame
      run(FRAME / 2, 0);
      bank_sel = 1'b1;
      run(FRAME + FRAME / 2, 0);
      run(3 * FRAME, 2);
      // Reset mid-frame at a known screen position
      rst = 1'b1;
      run(2, 0);
      rst = 1'b0;
      run(25 * HT + 30, 0);
      rst = 1'b1;
      run(1, 0);
      rst = 1'b0;
      run(FRAME + 100, 1);
      run($urandom_range(100, 3000), 1);
      rst = 1'b1;
      run($urandom_range(1, 3), 0);
      bank_sel = ~bank_sel;
      rst = 1'b0;
      run(FRAME + 200, 0);
      run(3, 0);
      if (checks < 12) begin
         errors++;
         $display("FAIL check_count: got %0d expected at least 12", checks);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
